// File: rtl/mod_fetch_unit.sv
// Instruction fetch unit: two-line circular byte buffer feeding a decoder window from a tagged icache.
// Optional FETCH_PREFETCH_EN: request the next line whenever a buffer line is free.
module mod_fetch_unit #(
   parameter int LINEBYTES = 64,
   parameter int WINBYTES  = 16,
   parameter int TAGWIDTH  = 13
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   redirect_valid,
   input  logic [63:0]            redirect_pc,
   output logic [63:0]            req,
   output logic [TAGWIDTH-1:0]    reqtag,
   output logic                   reqcyc,
   input  logic                   reqack,
   input  logic [8*LINEBYTES-1:0] resp,
   input  logic [TAGWIDTH-1:0]    resptag,
   input  logic                   respcyc,
   output logic                   respack,
   output logic [8*WINBYTES-1:0]  win_data,
   output logic [63:0]            win_pc,
   output logic                   win_valid,
   input  logic [4:0]             consume
);
   localparam int OW = $clog2(LINEBYTES);
   localparam int BW = OW + 1;
   localparam int CW = BW + 1;
   localparam logic [CW-1:0] LINE_CNT = CW'(LINEBYTES);
   localparam logic [CW-1:0] WIN_CNT  = CW'(WINBYTES);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t state, state_nxt;

   // Byte at PC p lives at buf_mem[p mod 2*LINEBYTES], so line slot = address bit OW.
   logic [7:0]          buf_mem [2*LINEBYTES];
   logic [CW-1:0]       valid_cnt;
   logic [63:0]         fetch_addr;
   logic [OW-1:0]       skip;
   logic                epoch;
   logic                started;
   logic [TAGWIDTH-2:0] seq;

   logic [CW-1:0] span;
   logic [CW-1:0] cons_amt;
   logic          want_req;
   logic          resp_take;
   logic          unused_tag;

   assign unused_tag = ^resptag[TAGWIDTH-1:1];

   // Bytes from the start of win_pc's line to the end of fetched data; <= one line means a slot is free.
   assign span      = CW'(win_pc[OW-1:0]) + valid_cnt;
   assign win_valid = (valid_cnt >= WIN_CNT);
   assign cons_amt  = !win_valid ? '0 :
                      (CW'(consume) > WIN_CNT) ? WIN_CNT : CW'(consume);
   assign resp_take = respcyc && (state == S_WAIT) && started &&
                      (resptag[0] == epoch) && !redirect_valid;

`ifdef FETCH_PREFETCH_EN
   assign want_req = started && (span <= LINE_CNT);
`else
   assign want_req = started && (valid_cnt < WIN_CNT);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (want_req && !redirect_valid) state_nxt = S_REQ;
         S_REQ:   if (reqack) state_nxt = S_WAIT;
         S_WAIT:  if (respcyc) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      reqcyc  = (state == S_REQ);
      respack = respcyc;
   end

   // Address and tag are captured only on entry to REQ, so they hold across redirects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req    <= '0;
         reqtag <= '0;
         seq    <= '0;
      end else if (state == S_IDLE && state_nxt == S_REQ) begin
         req    <= fetch_addr;
         reqtag <= {seq, epoch};
         seq    <= seq + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_cnt  <= '0;
         win_pc     <= '0;
         fetch_addr <= '0;
         skip       <= '0;
         epoch      <= 1'b0;
         started    <= 1'b0;
      end else if (redirect_valid) begin
         epoch      <= ~epoch;
         started    <= 1'b1;
         win_pc     <= redirect_pc;
         valid_cnt  <= '0;
         fetch_addr <= {redirect_pc[63:OW], {OW{1'b0}}};
         skip       <= redirect_pc[OW-1:0];
      end else begin
         win_pc    <= win_pc + 64'(cons_amt);
         valid_cnt <= valid_cnt - cons_amt + (resp_take ? (LINE_CNT - CW'(skip)) : '0);
         if (resp_take) begin
            fetch_addr <= fetch_addr + 64'(LINEBYTES);
            skip       <= '0;
         end
      end
   end

   // NOTE: the byte buffer has no reset; valid_cnt guards every read, so stale contents are never exposed.
   always_ff @(posedge clk) begin
      if (resp_take)
         for (int k = 0; k < LINEBYTES; k++)
            buf_mem[{fetch_addr[OW], OW'(k)}] <= resp[8*k +: 8];
   end

   always_comb begin
      win_data = '0;
      if (win_valid)
         for (int i = 0; i < WINBYTES; i++)
            win_data[8*i +: 8] = buf_mem[win_pc[BW-1:0] + BW'(i)];
   end
endmodule

// File: doc/mod_fetch_unit.md
MOD_FETCH_UNIT -- requirements
Module: mod_fetch_unit

Interface
REQ-001 SHALL have parameter LINEBYTES, default 64, meaning the cache line size in bytes (512-bit response).
REQ-002 SHALL have parameter WINBYTES, default 16, meaning the decoder window width in bytes.
REQ-003 SHALL have parameter TAGWIDTH, default 13, meaning the width of reqtag/resptag.
REQ-004 SHALL have these ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  load a new fetch PC (branch/startup).
- redirect_pc  in  64  new byte PC.
- req  out  64  line-aligned fetch address to icache.
- reqtag  out  TAGWIDTH  request tag; bit 0 = epoch.
- reqcyc  out  1  request valid.
- reqack  in  1  icache accepted request.
- resp  in  512  line data; byte k at bits [8k+7:8k].
- resptag  in  TAGWIDTH  response tag.
- respcyc  in  1  response valid.
- respack  out  1  response accepted.
- win_data  out  8*WINBYTES  bytes at win_pc upward; byte 0 in LSBs.
- win_pc  out  64  PC of win_data byte 0.
- win_valid  out  1  all WINBYTES bytes of window are present.
- consume  in  5  bytes retired by decoder this cycle (0..16).

Function
REQ-005 SHALL hold a 2-line circular byte buffer, a decode pointer (win_pc), a next-fetch line address, a valid-byte count (0..128), an outstanding-request flag and a 1-bit epoch.
REQ-006 SHALL run FSM IDLE -> REQ (reqcyc=1, req/reqtag stable) -> WAIT (reqack seen) -> IDLE on respcyc; at most one request outstanding.
REQ-007 SHALL leave REQ only in the cycle reqack=1; req, reqtag and reqcyc SHALL not change while reqcyc=1 and reqack=0.
REQ-008 SHALL drive respack = respcyc combinationally.
REQ-009 SHALL, on respcyc with resptag[0]==epoch, write resp into the free buffer line, add LINEBYTES to valid count, advance next-fetch address by LINEBYTES (wrapping modulo 2^64).
REQ-010 SHALL, on respcyc with resptag[0]!=epoch, acknowledge and discard the data with no buffer change, and return to IDLE.
REQ-011 SHALL drive win_valid=1 iff valid count >= WINBYTES; the window may span both buffer lines.
REQ-012 SHALL, when win_valid=1, advance win_pc and reduce valid count by consume (values >16 clamped to 16); consume is ignored when win_valid=0.
REQ-013 SHALL free a buffer line in the cycle win_pc crosses a line boundary.
REQ-014 SHALL, on redirect_valid, in the next cycle: toggle epoch, set win_pc=redirect_pc, valid count=0, next-fetch = redirect_pc with low 6 bits cleared, and skip the first (redirect_pc mod 64) bytes of the next accepted line.
REQ-015 SHALL keep an unacknowledged request asserted with its old address/tag across a redirect; its response is then discarded per REQ-010.
REQ-016 SHALL give redirect priority over consume and over an accepted response in the same cycle.
REQ-017 SHALL, with a line free and no request outstanding, issue a request in the cycle after the condition arises.
REQ-018 SHALL use 64-bit wrapping arithmetic for all PC and address updates.

Reset
REQ-019 SHALL, while reset=0: reqcyc=0, req=0, reqtag=0, win_valid=0, win_pc=0, win_data=0, valid count=0, epoch=0, FSM=IDLE, no fetching until first redirect_valid.
REQ-020 SHALL, on reset assertion mid-request, drop reqcyc immediately; responses after reset release SHALL be discarded until the first post-reset redirect.

Configuration
REQ-021 SHALL, with FETCH_PREFETCH_EN defined, request the next line whenever a buffer line is free (REQ-017).
REQ-022 SHALL, without FETCH_PREFETCH_EN, request a line only when valid count < WINBYTES.

Verification
REQ-023 Reset, then redirect to 0x1000; icache acks after 2 cycles, responds line with bytes 0x00..0x3F -> req=0x1000, win_pc=0x1000, win_valid=1, win_data bytes 0x00..0x0F.
REQ-024 Redirect to 0x1038; lines 0x1000 and 0x1040 returned -> window bytes 0x38..0x3F followed by first 8 bytes of line 0x1040.
REQ-025 Redirect issued while reqcyc=1 and reqack=0 -> request held unchanged; its response acked and dropped; next req uses redirected line, epoch toggled.
REQ-026 consume=16 every cycle with 1-cycle icache -> win_pc advances 16/cycle, no lost or duplicated bytes across 0x...FFC0 -> 0x0 wrap.
REQ-027 With FETCH_PREFETCH_EN, line 2 requested while line 1 still in window; without it, no request until valid count < 16.
